// File: rtl/game_pkg.sv
// game_pkg: types and defaults shared by the game blocks.
//   hp_state_t    per-entity health state
//   BOSS_MAX_HP   default restart HP
//   BAR_*_DEF     default HP bar geometry and colour
//   bar_row_top() top row of the stacked bar with a given index
package game_pkg;

  typedef enum logic [1:0] {
    HP_ALIVE = 2'd0,
    HP_HURT  = 2'd1,
    HP_DEAD  = 2'd2
  } hp_state_t;

  localparam int          BOSS_MAX_HP    = 100;
  localparam int          IFRAME_CYC_DEF = 16;
  localparam int          BAR_W_DEF      = 100;
  localparam int          BAR_H_DEF      = 8;
  localparam int          BAR_GAP_DEF    = 4;
  localparam int          BAR_Y0_DEF     = 10;
  localparam logic [11:0] BAR_RGB_DEF    = 12'hF00;

  function automatic int bar_row_top(input int idx, input int y0, input int h, input int gap);
    return y0 + idx * (h + gap);
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// vga_pkg: display geometry shared by the VGA render chain.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

endpackage

// File: rtl/vga_if.sv
// vga_if: one stage of the VGA timing/pixel stream.
//   modport in  : consumer side (all fields are inputs)
//   modport out : producer side (all fields are outputs)
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/entity_hp_fsm.sv
// entity_hp_fsm: health of a single entity.
//   clk, rst           clock, synchronous active-high reset
//   restart            level; reload to MAX_HP / ALIVE
//   active             game is running (damage and iframe countdown enabled)
//   hit, dmg           hit strobe and damage amount
//   remote_valid/_hp   HP sample from player 2, merged with min()
//   hp                 registered current HP
//   state              current FSM state (also used for debug/checkers)
//   dead, death_pulse  DEAD level and one-cycle strobe on entry to DEAD
module entity_hp_fsm
  import game_pkg::*;
#(
  parameter int HP_W       = 8,
  parameter int MAX_HP     = BOSS_MAX_HP,
  parameter int IFRAME_CYC = IFRAME_CYC_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            restart,
  input  logic            active,
  input  logic            hit,
  input  logic [HP_W-1:0] dmg,
  input  logic            remote_valid,
  input  logic [HP_W-1:0] remote_hp,
  output logic [HP_W-1:0] hp,
  output hp_state_t       state,
  output logic            dead,
  output logic            death_pulse
);

  // Counter holds IFRAME_CYC-1 down to 0, so HURT spans IFRAME_CYC cycles.
  localparam int CNT_W = (IFRAME_CYC > 1) ? $clog2(IFRAME_CYC) : 1;

  hp_state_t        state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             hit_ok;
  logic [HP_W-1:0]  nh;
  logic [HP_W-1:0]  cand;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      state_q <= HP_ALIVE;
      hp_q    <= HP_W'(MAX_HP);
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    hit_ok  = (state_q == HP_ALIVE) && hit && (dmg != '0) && active;
    nh      = (dmg >= hp_q) ? '0 : hp_q - dmg;
    cand    = hit_ok ? nh : hp_q;
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      HP_ALIVE, HP_HURT: begin
        // Remote merge applies whatever game_active is; it never starts iframes.
        hp_d = (remote_valid && (remote_hp < cand)) ? remote_hp : cand;
        if ((state_q == HP_HURT) && active) begin
          if (cnt_q == '0) state_d = HP_ALIVE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        if (hp_d == '0) begin
          state_d = HP_DEAD;
          pulse_d = 1'b1;
          cnt_d   = '0;
        end else if (hit_ok && (IFRAME_CYC > 0)) begin
          state_d = HP_HURT;
          cnt_d   = CNT_W'(IFRAME_CYC - 1);
        end
      end
      default: begin
        state_d = HP_DEAD;
        hp_d    = '0;
      end
    endcase
  end

  assign hp          = hp_q;
  assign state       = state_q;
  assign dead        = (state_q == HP_DEAD);
  assign death_pulse = pulse_q;

endmodule

// File: rtl/entity_hp_bank.sv
// entity_hp_bank: HP manager for N_ENT entities plus stacked HP bar overlay.
//   clk, rst        clock, synchronous active-high reset
//   restart         level; reloads every entity (priority below rst only)
//   game_active     damage, iframe countdown and bars enabled only when == 1
//   hit, dmg        per-entity hit strobe and damage, dmg[i*HP_W +: HP_W]
//   remote_valid    remote_hp is valid this cycle; valid-only, there is no
//                   ready: the sample is consumed in every cycle valid is high
//   remote_hp       player 2 HP, same packing as dmg, merged with min()
//   vga_in/vga_out  VGA stream, every field delayed exactly one cycle
//   hp              registered HP per entity, same packing as dmg
//   dead            per-entity DEAD level
//   death_pulse     per-entity one-cycle strobe on entry to DEAD
//   ent_state       per-entity hp_state_t, ent_state[i*2 +: 2]
// Optional macro ENT_HP_FLASH_EN: bar drawn white while HURT, not drawn when DEAD.
module entity_hp_bank
  import game_pkg::*;
  import vga_pkg::*;
#(
  parameter int          N_ENT      = 2,
  parameter int          HP_W       = 8,
  parameter int          MAX_HP     = BOSS_MAX_HP,
  parameter int          IFRAME_CYC = IFRAME_CYC_DEF,
  parameter int          BAR_W      = BAR_W_DEF,
  parameter int          BAR_H      = BAR_H_DEF,
  parameter int          BAR_GAP    = BAR_GAP_DEF,
  parameter int          BAR_X      = HOR_PIXELS - BAR_W - 10,
  parameter int          BAR_Y0     = BAR_Y0_DEF,
  parameter logic [11:0] BAR_RGB    = BAR_RGB_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic [1:0]            game_active,
  input  logic [N_ENT-1:0]      hit,
  input  logic [N_ENT*HP_W-1:0] dmg,
  input  logic                  remote_valid,
  input  logic [N_ENT*HP_W-1:0] remote_hp,
  vga_if.in                     vga_in,
  vga_if.out                    vga_out,
  output logic [N_ENT*HP_W-1:0] hp,
  output logic [N_ENT-1:0]      dead,
  output logic [N_ENT-1:0]      death_pulse,
  output logic [N_ENT*2-1:0]    ent_state
);

  localparam int BW_W   = $clog2(BAR_W + 1);
  localparam int PROD_W = HP_W + BW_W;

  logic                  active;
  logic [N_ENT*BW_W-1:0] bw_flat;
  logic [11:0]           pix_rgb;

  assign active = (game_active == 2'd1);

  for (genvar i = 0; i < N_ENT; i++) begin : g_ent
    hp_state_t       st;
    logic [BW_W-1:0] bw_q;
    logic [PROD_W-1:0] prod;

    entity_hp_fsm #(
      .HP_W      (HP_W),
      .MAX_HP    (MAX_HP),
      .IFRAME_CYC(IFRAME_CYC)
    ) u_fsm (
      .clk         (clk),
      .rst         (rst),
      .restart     (restart),
      .active      (active),
      .hit         (hit[i]),
      .dmg         (dmg[i*HP_W +: HP_W]),
      .remote_valid(remote_valid),
      .remote_hp   (remote_hp[i*HP_W +: HP_W]),
      .hp          (hp[i*HP_W +: HP_W]),
      .state       (st),
      .dead        (dead[i]),
      .death_pulse (death_pulse[i])
    );

    assign ent_state[i*2 +: 2] = st;

    // Product is wide enough for BAR_W*(2**HP_W-1); quotient never exceeds BAR_W.
    assign prod = PROD_W'(BAR_W) * PROD_W'(hp[i*HP_W +: HP_W]);

    always_ff @(posedge clk) begin
      if (rst || restart) bw_q <= BW_W'(BAR_W);
      else                bw_q <= BW_W'(prod / PROD_W'(MAX_HP));
    end

    assign bw_flat[i*BW_W +: BW_W] = bw_q;
  end

  always_comb begin
    pix_rgb = vga_in.rgb;
    if (active) begin
      for (int i = 0; i < N_ENT; i++) begin
        if ((int'(vga_in.vcount) >= bar_row_top(i, BAR_Y0, BAR_H, BAR_GAP)) &&
            (int'(vga_in.vcount) <  bar_row_top(i, BAR_Y0, BAR_H, BAR_GAP) + BAR_H) &&
            (int'(vga_in.hcount) >= BAR_X) &&
            (int'(vga_in.hcount) <  BAR_X + int'(bw_flat[i*BW_W +: BW_W]))) begin
`ifdef ENT_HP_FLASH_EN
          if (!dead[i]) pix_rgb = (ent_state[i*2 +: 2] == HP_HURT) ? 12'hFFF : BAR_RGB;
`else
          pix_rgb = BAR_RGB;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vga_out.hcount <= '0;
      vga_out.vcount <= '0;
      vga_out.hsync  <= 1'b0;
      vga_out.vsync  <= 1'b0;
      vga_out.hblnk  <= 1'b0;
      vga_out.vblnk  <= 1'b0;
      vga_out.rgb    <= '0;
    end else begin
      vga_out.hcount <= vga_in.hcount;
      vga_out.vcount <= vga_in.vcount;
      vga_out.hsync  <= vga_in.hsync;
      vga_out.vsync  <= vga_in.vsync;
      vga_out.hblnk  <= vga_in.hblnk;
      vga_out.vblnk  <= vga_in.vblnk;
      vga_out.rgb    <= pix_rgb;
    end
  end

endmodule

// File: tb/tb_entity_hp_bank.sv
module tb_entity_hp_bank;
  import game_pkg::*;

  localparam int N_ENT   = 2;
  localparam int HP_W    = 8;
  localparam int MAX_HP  = 100;
  localparam int IFRAME  = 16;
  localparam int BAR_W   = 100;
  localparam int BAR_H   = 8;
  localparam int BAR_GAP = 4;
  localparam int BAR_X   = 690;
  localparam int BAR_Y0  = 10;
  localparam int VW      = 38;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst, restart, remote_valid;
  logic [1:0] game_active;
  logic [N_ENT-1:0] hit, dead, death_pulse;
  logic [N_ENT*HP_W-1:0] dmg, remote_hp, hp;
  logic [N_ENT*2-1:0] ent_state;

  vga_if vin();
  vga_if vout();

  always #5 clk = ~clk;

  entity_hp_bank #(
    .N_ENT(N_ENT), .HP_W(HP_W), .MAX_HP(MAX_HP), .IFRAME_CYC(IFRAME),
    .BAR_W(BAR_W), .BAR_H(BAR_H), .BAR_GAP(BAR_GAP), .BAR_X(BAR_X),
    .BAR_Y0(BAR_Y0), .BAR_RGB(12'hF00)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart), .game_active(game_active),
    .hit(hit), .dmg(dmg), .remote_valid(remote_valid), .remote_hp(remote_hp),
    .vga_in(vin), .vga_out(vout),
    .hp(hp), .dead(dead), .death_pulse(death_pulse), .ent_state(ent_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model ----------------
  int  m_hp[N_ENT];
  int  m_left[N_ENT];   // remaining invulnerable cycles
  int  m_bw[N_ENT];
  bit  m_dead[N_ENT];
  bit  m_pulse[N_ENT];
  logic [VW-1:0] exp_vga;
  logic [VW-1:0] exp_q[$];

  function automatic bit m_hurt(input int i);
    return (m_left[i] > 0) && !m_dead[i];
  endfunction

  function automatic logic [VW-1:0] vout_word();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk, vout.rgb};
  endfunction

  // Advance model with the currently driven inputs, then one clock edge.
  task automatic tick();
    logic [11:0] e_rgb;
    int nbw[N_ENT];
    e_rgb = vin.rgb;
    if (game_active == 2'd1) begin
      for (int i = 0; i < N_ENT; i++) begin
        if (int'(vin.vcount) >= BAR_Y0 + i*(BAR_H+BAR_GAP) &&
            int'(vin.vcount) <  BAR_Y0 + i*(BAR_H+BAR_GAP) + BAR_H &&
            int'(vin.hcount) >= BAR_X && int'(vin.hcount) < BAR_X + m_bw[i]) begin
`ifdef ENT_HP_FLASH_EN
          if (!m_dead[i]) e_rgb = m_hurt(i) ? 12'hFFF : 12'hF00;
`else
          e_rgb = 12'hF00;
`endif
        end
      end
    end
    if (rst) exp_vga = '0;
    else exp_vga = {vin.hcount, vin.vcount, vin.hsync, vin.vsync, vin.hblnk, vin.vblnk, e_rgb};
    for (int i = 0; i < N_ENT; i++) nbw[i] = BAR_W * m_hp[i] / MAX_HP;
    for (int i = 0; i < N_ENT; i++) begin
      int d;
      int r;
      int cand;
      bit took;
      d = int'(dmg[i*HP_W +: HP_W]);
      r = int'(remote_hp[i*HP_W +: HP_W]);
      m_pulse[i] = 1'b0;
      if (rst || restart) begin
        m_hp[i] = MAX_HP; m_left[i] = 0; m_dead[i] = 1'b0; m_bw[i] = BAR_W;
      end else begin
        m_bw[i] = nbw[i];
        if (!m_dead[i]) begin
          cand = m_hp[i];
          took = 1'b0;
          if (game_active == 2'd1 && hit[i] && d != 0 && m_left[i] == 0) begin
            cand = (d >= cand) ? 0 : cand - d;
            took = 1'b1;
          end else if (m_left[i] > 0 && game_active == 2'd1) begin
            m_left[i]--;
          end
          if (remote_valid && r < cand) cand = r;
          m_hp[i] = cand;
          if (cand == 0) begin
            m_dead[i] = 1'b1; m_pulse[i] = 1'b1; m_left[i] = 0;
          end else if (took && IFRAME > 0) begin
            m_left[i] = IFRAME;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    rst = 1'b0; restart = 1'b0; hit = '0; dmg = '0;
    remote_valid = 1'b0; remote_hp = '0;
  endtask

  task automatic drive_hit(input int i, input int d);
    hit[i] = 1'b1;
    dmg[i*HP_W +: HP_W] = HP_W'(d);
  endtask

  task automatic drive_remote(input int r0, input int r1);
    remote_valid = 1'b1;
    remote_hp = {HP_W'(r1), HP_W'(r0)};
  endtask

  task automatic drive_pix(input int hc, input int vc, input logic [11:0] rgb);
    vin.hcount = 11'(hc); vin.vcount = 11'(vc); vin.rgb = rgb;
  endtask

  task automatic do_restart();
    idle(); restart = 1'b1; tick(); restart = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle(); game_active = 2'd1;
    drive_pix(700, 12, 12'h123); vin.hsync = 1'b1; vin.vblnk = 1'b1;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    n_checks++;
    if (hp !== {8'd100, 8'd100}) begin n_errors++; $display("FAIL reset_hp got %h exp %h", hp, {8'd100, 8'd100}); end
    n_checks++;
    if (dead !== 2'b00 || death_pulse !== 2'b00) begin n_errors++; $display("FAIL reset_dead got %b/%b exp 00/00", dead, death_pulse); end
    n_checks++;
    if (ent_state !== {HP_ALIVE, HP_ALIVE}) begin n_errors++; $display("FAIL reset_state got %b exp alive", ent_state); end
    n_checks++;
    if (vout_word() !== '0) begin n_errors++; $display("FAIL reset_vga got %h exp 0", vout_word()); end
    vin.hsync = 1'b0; vin.vblnk = 1'b0;
  endtask

  task automatic test_hit_iframe();
    do_restart(); game_active = 2'd1;
    drive_hit(0, 10); tick(); idle();
    n_checks++;
    if (hp[7:0] !== 8'd90 || ent_state[1:0] !== HP_HURT) begin n_errors++; $display("FAIL hit10 got hp %0d st %0d exp 90 hurt", hp[7:0], ent_state[1:0]); end
    for (int k = 1; k <= 17; k++) begin
      idle();
      if (k == 5 || k == 17) drive_hit(0, 10);
      tick();
      n_checks++;
      if (hp[7:0] !== 8'(m_hp[0]) || (ent_state[1:0] == HP_HURT) !== m_hurt(0)) begin
        n_errors++; $display("FAIL iframe_k%0d got hp %0d st %0d exp hp %0d hurt %0d", k, hp[7:0], ent_state[1:0], m_hp[0], m_hurt(0));
      end
      if (k == 15) begin
        n_checks++;
        if (ent_state[1:0] !== HP_HURT) begin n_errors++; $display("FAIL iframe_len_still got st %0d exp hurt", ent_state[1:0]); end
      end
      if (k == 16) begin
        n_checks++;
        if (ent_state[1:0] !== HP_ALIVE || hp[7:0] !== 8'd90) begin n_errors++; $display("FAIL iframe_end got st %0d hp %0d exp alive 90", ent_state[1:0], hp[7:0]); end
      end
    end
    n_checks++;
    if (hp[7:0] !== 8'd80) begin n_errors++; $display("FAIL hit_after_iframe got %0d exp 80", hp[7:0]); end
    idle();
  endtask

  task automatic test_death();
    do_restart(); game_active = 2'd1;
    drive_remote(255, 7); tick(); idle();
    n_checks++;
    if (hp[15:8] !== 8'd7 || hp[7:0] !== 8'd100) begin n_errors++; $display("FAIL remote7 got %h exp 0764", hp); end
    drive_hit(1, 20); tick(); idle();
    n_checks++;
    if (hp[15:8] !== 8'd0 || dead[1] !== 1'b1 || death_pulse[1] !== 1'b1) begin
      n_errors++; $display("FAIL death got hp %0d dead %b pulse %b exp 0 1 1", hp[15:8], dead[1], death_pulse[1]);
    end
    tick();
    n_checks++;
    if (death_pulse[1] !== 1'b0 || dead[1] !== 1'b1) begin n_errors++; $display("FAIL pulse_once got pulse %b dead %b exp 0 1", death_pulse[1], dead[1]); end
    drive_hit(1, 5); drive_remote(255, 0); tick(); idle(); tick();
    n_checks++;
    if (hp[15:8] !== 8'd0 || death_pulse !== 2'b00 || ent_state[3:2] !== HP_DEAD) begin
      n_errors++; $display("FAIL dead_terminal got hp %0d pulse %b st %0d exp 0 00 dead", hp[15:8], death_pulse, ent_state[3:2]);
    end
  endtask

  task automatic test_inactive_remote();
    do_restart(); game_active = 2'd2;
    drive_hit(0, 10); tick(); idle();
    n_checks++;
    if (hp[7:0] !== 8'd100) begin n_errors++; $display("FAIL inactive_hit got %0d exp 100", hp[7:0]); end
    drive_remote(60, 255); tick(); idle();
    n_checks++;
    if (hp[7:0] !== 8'd60 || ent_state[1:0] === HP_HURT) begin n_errors++; $display("FAIL remote60 got hp %0d st %0d exp 60 not hurt", hp[7:0], ent_state[1:0]); end
    game_active = 2'd1;
  endtask

  task automatic test_same_cycle();
    do_restart(); game_active = 2'd1;
    drive_remote(50, 255); tick(); idle();
    n_checks++;
    if (hp[7:0] !== 8'd50 || ent_state[1:0] !== HP_ALIVE) begin n_errors++; $display("FAIL pre50 got hp %0d st %0d exp 50 alive", hp[7:0], ent_state[1:0]); end
    drive_hit(0, 5); drive_remote(48, 255); tick(); idle();
    n_checks++;
    if (hp[7:0] !== 8'd45 || ent_state[1:0] !== HP_HURT) begin n_errors++; $display("FAIL hit_and_remote got hp %0d st %0d exp 45 hurt", hp[7:0], ent_state[1:0]); end
    tick(); tick();
    do_restart();
    n_checks++;
    if (hp[7:0] !== 8'd100 || ent_state[1:0] !== HP_ALIVE) begin n_errors++; $display("FAIL restart_hurt got hp %0d st %0d exp 100 alive", hp[7:0], ent_state[1:0]); end
  endtask

  task automatic test_bar();
    logic [11:0] hurt_rgb;
    do_restart(); game_active = 2'd1;
    drive_remote(50, 255); tick(); idle(); tick();
    drive_pix(BAR_X + 49, BAR_Y0, 12'h0A5); tick();
    n_checks++;
    if (vout.rgb !== 12'hF00) begin n_errors++; $display("FAIL bar0_last got %h exp F00", vout.rgb); end
    drive_pix(BAR_X + 50, BAR_Y0, 12'h0A5); tick();
    n_checks++;
    if (vout.rgb !== 12'h0A5) begin n_errors++; $display("FAIL bar0_past got %h exp 0A5", vout.rgb); end
    drive_pix(BAR_X, 22, 12'h031); tick();
    n_checks++;
    if (vout.rgb !== 12'hF00) begin n_errors++; $display("FAIL bar1_top got %h exp F00", vout.rgb); end
    drive_pix(BAR_X, 21, 12'h031); tick();
    n_checks++;
    if (vout.rgb !== 12'h031) begin n_errors++; $display("FAIL bar1_above got %h exp 031", vout.rgb); end
    drive_pix(BAR_X, 30, 12'h031); tick();
    n_checks++;
    if (vout.rgb !== 12'h031) begin n_errors++; $display("FAIL bar1_below got %h exp 031", vout.rgb); end
    game_active = 2'd0; drive_pix(BAR_X, BAR_Y0, 12'h777); tick(); game_active = 2'd1;
    n_checks++;
    if (vout.rgb !== 12'h777) begin n_errors++; $display("FAIL bar_inactive got %h exp 777", vout.rgb); end
    drive_pix(123, 456, 12'h9C3); vin.hsync = 1'b1; vin.vsync = 1'b0; vin.hblnk = 1'b1; vin.vblnk = 1'b0;
    tick();
    n_checks++;
    if (vout_word() !== {11'd123, 11'd456, 4'b1010, 12'h9C3}) begin n_errors++; $display("FAIL vga_delay got %h exp %h", vout_word(), {11'd123, 11'd456, 4'b1010, 12'h9C3}); end
    vin.hsync = 1'b0; vin.hblnk = 1'b0;
`ifdef ENT_HP_FLASH_EN
    hurt_rgb = 12'hFFF;
`else
    hurt_rgb = 12'hF00;
`endif
    drive_hit(0, 5); drive_pix(BAR_X, BAR_Y0, 12'h0A5); tick(); idle(); tick();
    n_checks++;
    if (vout.rgb !== hurt_rgb) begin n_errors++; $display("FAIL bar_hurt got %h exp %h", vout.rgb, hurt_rgb); end
    drive_pix(BAR_X + 45, BAR_Y0, 12'h0A5); tick();
    n_checks++;
    if (vout.rgb !== 12'h0A5) begin n_errors++; $display("FAIL bar_shrunk got %h exp 0A5", vout.rgb); end
    drive_pix(BAR_X, BAR_Y0, 12'h0A5);
    for (int k = 0; k < IFRAME; k++) tick();
    n_checks++;
    if (vout.rgb !== 12'hF00 || ent_state[1:0] !== HP_ALIVE) begin n_errors++; $display("FAIL bar_after_iframe got %h st %0d exp F00 alive", vout.rgb, ent_state[1:0]); end
  endtask

  task automatic test_random();
    logic [VW-1:0] exp_w;
    int vga_bad;
    int ent_bad;
    vga_bad = 0; ent_bad = 0;
    do_restart();
    for (int c = 0; c < 600; c++) begin
      idle();
      restart = ($urandom_range(0, 59) == 0);
      game_active = ($urandom_range(0, 9) < 7) ? 2'd1 : 2'($urandom_range(0, 3));
      for (int i = 0; i < N_ENT; i++) begin
        if ($urandom_range(0, 3) == 0) drive_hit(i, $urandom_range(0, 30));
      end
      if ($urandom_range(0, 7) == 0) drive_remote($urandom_range(0, 255), $urandom_range(0, 255));
      drive_pix($urandom_range(BAR_X - 5, 799), $urandom_range(0, 35), 12'($urandom));
      vin.hsync = 1'($urandom); vin.vsync = 1'($urandom);
      vin.hblnk = 1'($urandom); vin.vblnk = 1'($urandom);
      tick();
      exp_q.push_back(exp_vga);
      exp_w = exp_q.pop_front();
      n_checks++;
      if (vout_word() !== exp_w) begin
        n_errors++; vga_bad++;
        if (vga_bad <= 5) $display("FAIL rand_vga c%0d got %h exp %h", c, vout_word(), exp_w);
      end
      for (int i = 0; i < N_ENT; i++) begin
        n_checks++;
        if (hp[i*HP_W +: HP_W] !== 8'(m_hp[i]) || dead[i] !== m_dead[i] ||
            death_pulse[i] !== m_pulse[i] || (ent_state[i*2 +: 2] == HP_HURT) !== m_hurt(i)) begin
          n_errors++; ent_bad++;
          if (ent_bad <= 5)
            $display("FAIL rand_ent%0d c%0d got hp %0d dead %b pulse %b st %0d exp hp %0d dead %b pulse %b hurt %b",
                     i, c, hp[i*HP_W +: HP_W], dead[i], death_pulse[i], ent_state[i*2 +: 2],
                     m_hp[i], m_dead[i], m_pulse[i], m_hurt(i));
        end
      end
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle(); game_active = 2'd0;
    drive_pix(0, 0, 12'h000);
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    test_reset();
    test_hit_iframe();
    test_death();
    test_inactive_remote();
    test_same_cycle();
    test_bar();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/entity_hp_bank.md
Name: entity_hp_bank

Overview:
Parametrised health manager for N_ENT independent entities (boss, boss phases, minions). It handles variable-size damage with saturating subtraction, invulnerability frames, death detection and min-merge against HP received from player 2. It also draws one stacked HP bar per entity into the VGA stream. It sits in the VGA render chain and replaces the single-entity fixed-damage HP block.

Parameters:
N_ENT, 2, number of entities/bars
HP_W, 8, HP and damage width in bits
MAX_HP, 100, restart HP, must be < 2**HP_W
IFRAME_CYC, 16, invulnerability length in clk cycles after a non-lethal hit; 0 disables
BAR_W, 100, bar length in pixels at full HP
BAR_H, 8, bar height in pixels
BAR_GAP, 4, vertical gap between bars in pixels
BAR_X, HOR_PIXELS-BAR_W-10, bar left edge
BAR_Y0, 10, top edge of bar 0
BAR_RGB, 12'hF00, bar colour

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
restart  in  1  level; reloads all entities (game_start OR player2_game_start)
game_active  in  2  damage and bars enabled only when value == 1
hit  in  N_ENT  per-entity hit strobe, one cycle per hit
dmg  in  N_ENT*HP_W  per-entity damage; entity i uses slice [i*HP_W +: HP_W]
remote_valid  in  1  remote_hp is valid this cycle
remote_hp  in  N_ENT*HP_W  HP reported by player 2, same packing as dmg
vga_in  vga_if.in  -  upstream timing and rgb
vga_out  vga_if.out  -  downstream, 1-cycle delayed
hp  out  N_ENT*HP_W  registered current HP, same packing as dmg
dead  out  N_ENT  level, entity is in DEAD
death_pulse  out  N_ENT  single-cycle strobe on entry to DEAD

Behaviour:
- Reset/restart: rst or restart forces every entity to hp=MAX_HP, state ALIVE, iframe counter 0, dead=0, death_pulse=0, bar width register=BAR_W. Restart has priority over everything except rst. vga_out fields reset to 0.
- Per-entity FSM:
  - ALIVE: accepts a hit when hit[i]=1, dmg[i]!=0 and game_active==1. Computes nh = (dmg>=hp) ? 0 : hp-dmg. nh==0 -> DEAD. nh>0 and IFRAME_CYC>0 -> HURT, counter loads IFRAME_CYC-1. nh>0 and IFRAME_CYC==0 -> stays ALIVE.
  - HURT: hits are ignored. Counter decrements each cycle; at 0, moves to ALIVE next cycle. HURT therefore lasts exactly IFRAME_CYC cycles. Counter freezes while game_active!=1.
  - DEAD: terminal; only rst/restart leave it. hp stays 0.
- Remote merge, any state except DEAD, regardless of game_active: when remote_valid=1, hp <= min(candidate, remote_hp[i]). The candidate is nh if a hit is accepted in the same cycle, otherwise the current hp. A merged result of 0 -> DEAD. A remote-only decrease does not enter HURT.
- death_pulse[i] is 1 for exactly the cycle after hp becomes 0. It never re-fires until after restart.
- hp output updates 1 cycle after the accepted hit or remote sample.
- Bar width: bw[i] = (BAR_W*hp[i])/MAX_HP, truncated. It is registered, so it lags hp by 1 cycle. Intermediate width is HP_W+clog2(BAR_W+1) bits, with no overflow.
- Rendering: only when game_active==1. Bar i occupies rows BAR_Y0+i*(BAR_H+BAR_GAP) up to BAR_H rows below. Columns are BAR_X <= hcount < BAR_X+bw[i]. Pixels inside a bar get BAR_RGB; all other pixels pass vga_in.rgb through.
- All vga_in fields (hcount, vcount, hsync, vsync, hblnk, vblnk, rgb) are registered to vga_out with exactly 1 cycle latency.

Optional Feature:
ENT_HP_FLASH_EN
- Defined: an entity in HURT draws its bar in 12'hFFF instead of BAR_RGB; DEAD draws nothing.
- Undefined: BAR_RGB is always used and no extra logic is generated.

Decomposition:
- Shared package game_pkg:
  - typedef enum logic [1:0] {HP_ALIVE, HP_HURT, HP_DEAD} hp_state_t
  - BOSS_MAX_HP default constant
  - bar geometry defaults
- vga_pkg supplies HOR_PIXELS.
- Sub-module entity_hp_fsm holds one entity's hp, state, iframe counter and death pulse. It is instantiated N_ENT times via generate.
- The top level does rendering and the VGA pipeline.

Test Plan:
- rst, then game_active=1, hit[0] with dmg=10 -> hp0=90 next cycle. HURT lasts 16 cycles; a hit on cycle 5 is ignored, a hit on cycle 17 gives hp0=80.
- hp1=7, dmg=20 -> hp1=0, dead[1]=1, death_pulse[1] high exactly 1 cycle. Further hits and remote updates leave hp1=0 and no pulse.
- game_active=2, hit[0] with dmg=10 -> hp unchanged. remote_valid with remote_hp0=60 -> hp0=60 and state not HURT.
- Same cycle: hit dmg=5 on hp=50 and remote 48 -> hp=45, state HURT. Then restart mid-HURT -> hp=100, ALIVE next cycle.
- hp0=50 -> bw0=50. Pixel (BAR_X+49, BAR_Y0) is F00 and (BAR_X+50, BAR_Y0) is passthrough. Bar 1 starts at row 22. All vga_out fields are delayed by 1 cycle.
- With ENT_HP_FLASH_EN defined: pixel inside bar 0 during HURT is FFF, and returns to F00 after IFRAME_CYC cycles.
